jk_ff_bank: RTL



---
 rtl/jk_ff_bank.sv | 88 ++++++++
 1 files changed

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: a bank of WIDTH flip-flops whose next-state rule (JK, D, T
// or SR) is selected at run time. It also provides a synchronous parallel
// load, per-bit change flags, a sticky error flag for illegal SR input, and
// a saturating counter of edges on which any bit changed.
//
// Priority at each rising edge of clk: rst > load > en > hold.
module jk_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_stat,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] chg,
    output logic             sr_err,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] chg_next;
    logic             sr_set;

    // Compute the next state from load/en/mode, and detect an illegal SR input.
    always_comb begin
        q_next = q;
        sr_set = 1'b0;
        if (load) begin
            q_next = load_data;
        end else if (en) begin
            case (mode)
                MODE_JK: q_next = (j & ~q) | (~k & q);
                MODE_D:  q_next = j;
                MODE_T:  q_next = q ^ j;
                MODE_SR: begin
                    // In SR mode a bit with S=R=1 gets neither set nor
                    // clear, so it holds its value.
                    q_next = (q | (j & ~k)) & ~(~j & k);
                    sr_set = |(j & k);
                end
            endcase
        end
    end

    assign chg_next = q_next ^ q;
    assign qbar     = ~q;

    // Register the state and the change flags. clr_stat takes priority
    // over a set of sr_err or an increment of evt_cnt on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RESET_VAL;
            chg     <= '0;
            sr_err  <= 1'b0;
            evt_cnt <= '0;
        end else begin
            q   <= q_next;
            chg <= chg_next;
            if (clr_stat) begin
                sr_err  <= 1'b0;
                evt_cnt <= '0;
            end else begin
                if (sr_set) begin
                    sr_err <= 1'b1;
                end
                if ((chg_next != '0) && (evt_cnt != CNT_MAX)) begin
                    evt_cnt <= evt_cnt + 1'b1;
                end
            end
        end
    end

endmodule
